gfx_scanin_adc: RTL and testbench

Frame-capture front end: accepts an Avalon-ST video stream (`rgb30` beats framed by start/endofpacket) and writes each pixel into VRAM as two `vram_word` halves through an Avalon-MM write master. It is the receive-side counterpart of the scanout DAC path: it narrows 10-bit channels back to `rgb24`, packs an `rgb32` with opaque alpha, and produces the same `{msw, lsw}` word ordering the scanout FIFO consumes. It sits between a video-in source (or loopback) and the VRAM arbiter.

---
 rtl/gfx_scanin_adc.sv | 194 +++++++++++++++++++
 tb/tb_gfx_scanin_adc.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_scanin_adc.sv
// Frame-capture front end: narrows an rgb30 video stream to rgb32 (opaque alpha)
// and writes each pixel into VRAM as an lsw/msw pair through an Avalon-MM master.

package gfx_defs;
  localparam int GFX_X_RES = 8;
  localparam int GFX_Y_RES = 4;

  typedef logic [15:0] half_coord;
  typedef logic [15:0] linear_coord;
  typedef logic [15:0] vram_word;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb32;
endpackage

module gfx_scanin_adc
  import gfx_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  half_coord  fb_base,
  input  logic       scan_valid,
  output logic       scan_ready,
  input  logic       scan_startofpacket,
  input  logic       scan_endofpacket,
  input  rgb30       scan_data,
  output logic       fb_write,
  output half_coord  fb_address,
  output vram_word   fb_writedata,
  input  logic       fb_waitrequest,
  output logic       frame_done,
  output logic       frame_err
);

  localparam linear_coord MAX_ADDR = linear_coord'(GFX_X_RES * GFX_Y_RES - 1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_WAIT,
    S_WR_LO,
    S_WR_HI
  } state_t;

  state_t      state_q, state_d;
  linear_coord pixel_addr_q, pixel_addr_d;
  half_coord   base_q, base_d;
  rgb32        hold_q, hold_d;
  logic        last_q, last_d;
  logic        ok_q, ok_d;
  logic        scan_ready_q, scan_ready_d;
  logic        fb_write_q, fb_write_d;
  half_coord   fb_address_q, fb_address_d;
  vram_word    fb_writedata_q, fb_writedata_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic beat;
  logic capture;

  function automatic rgb32 narrow(input rgb30 px);
    rgb32 res;
    res.a = 8'hff;
    res.r = px.r[9:2];
    res.g = px.g[9:2];
    res.b = px.b[9:2];
    return res;
  endfunction

  assign beat = scan_valid && scan_ready_q;

  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no path leaves a
    // variable unassigned; that is what keeps this block free of inferred latches.
    state_d        = state_q;
    pixel_addr_d   = pixel_addr_q;
    base_d         = base_q;
    hold_d         = hold_q;
    last_d         = last_q;
    ok_d           = ok_q;
    scan_ready_d   = scan_ready_q;
    fb_write_d     = fb_write_q;
    fb_address_d   = fb_address_q;
    fb_writedata_d = fb_writedata_q;
    frame_done_d   = 1'b0;
    frame_err_d    = 1'b0;
    capture        = 1'b0;

    unique case (state_q)
      S_SYNC, S_WAIT: begin
        if (beat) begin
          if (scan_startofpacket) begin
            // A sop seen mid-frame is a resync: the old frame is abandoned.
            frame_err_d = (state_q == S_WAIT);
            if (enable) begin
              base_d       = fb_base;
              pixel_addr_d = '0;
              capture      = 1'b1;
            end else begin
              state_d = S_SYNC;
            end
          end else if (state_q == S_WAIT) begin
            capture = 1'b1;
          end
        end
      end
      S_WR_LO: begin
        if (!fb_waitrequest) begin
          state_d        = S_WR_HI;
          fb_address_d   = half_coord'(fb_address_q + 16'd1);
          fb_writedata_d = hold_q[31:16];
        end
      end
      S_WR_HI: begin
        if (!fb_waitrequest) begin
          fb_write_d   = 1'b0;
          scan_ready_d = 1'b1;
          if (last_q) begin
            state_d      = S_SYNC;
            pixel_addr_d = '0;
            frame_done_d = ok_q;
            frame_err_d  = !ok_q;
          end else begin
            state_d      = S_WAIT;
            pixel_addr_d = linear_coord'(pixel_addr_q + 16'd1);
          end
        end
      end
      default: state_d = S_SYNC;
    endcase

    // Shared by the first beat of a frame and every in-frame beat.
    if (capture) begin
      hold_d         = narrow(scan_data);
      last_d         = scan_endofpacket || (pixel_addr_d == MAX_ADDR);
      ok_d           = scan_endofpacket && (pixel_addr_d == MAX_ADDR);
      state_d        = S_WR_LO;
      scan_ready_d   = 1'b0;
      fb_write_d     = 1'b1;
      fb_address_d   = half_coord'(base_d + (half_coord'(pixel_addr_d) << 1));
      fb_writedata_d = hold_d[15:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SYNC;
      pixel_addr_q   <= '0;
      base_q         <= '0;
      hold_q         <= '0;
      last_q         <= 1'b0;
      ok_q           <= 1'b0;
      scan_ready_q   <= 1'b1;
      fb_write_q     <= 1'b0;
      fb_address_q   <= '0;
      fb_writedata_q <= '0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pixel_addr_q   <= pixel_addr_d;
      base_q         <= base_d;
      hold_q         <= hold_d;
      last_q         <= last_d;
      ok_q           <= ok_d;
      scan_ready_q   <= scan_ready_d;
      fb_write_q     <= fb_write_d;
      fb_address_q   <= fb_address_d;
      fb_writedata_q <= fb_writedata_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign scan_ready   = scan_ready_q;
  assign fb_write     = fb_write_q;
  assign fb_address   = fb_address_q;
  assign fb_writedata = fb_writedata_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_gfx_scanin_adc.sv
// Randomized bench for gfx_scanin_adc: a frame-level model predicts the VRAM write
// sequence and done/err pulses; a negedge monitor compares the DUT against it.

module tb_gfx_scanin_adc;
  import gfx_defs::*;

  localparam int MAX = GFX_X_RES * GFX_Y_RES - 1;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      enable = 1'b1;
  half_coord fb_base = '0;
  logic      scan_valid = 1'b0;
  logic      scan_ready;
  logic      scan_startofpacket = 1'b0;
  logic      scan_endofpacket = 1'b0;
  rgb30      scan_data = '0;
  logic      fb_write;
  half_coord fb_address;
  vram_word  fb_writedata;
  logic      fb_waitrequest = 1'b0;
  logic      frame_done;
  logic      frame_err;

  always #5 clk = ~clk;

  gfx_scanin_adc dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .fb_base            (fb_base),
    .scan_valid         (scan_valid),
    .scan_ready         (scan_ready),
    .scan_startofpacket (scan_startofpacket),
    .scan_endofpacket   (scan_endofpacket),
    .scan_data          (scan_data),
    .fb_write           (fb_write),
    .fb_address         (fb_address),
    .fb_writedata       (fb_writedata),
    .fb_waitrequest     (fb_waitrequest),
    .frame_done         (frame_done),
    .frame_err          (frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    half_coord addr;
    vram_word  data;
    bit        hi;
  } wr_t;

  wr_t       exp_wr[$];
  wr_t       wlog[$];
  bit        exp_ev[$];  // 1 = frame_done, 0 = frame_err
  bit        m_in_frame = 0;
  int        m_pix = 0;
  half_coord m_base = '0;
  int        n_done = 0, n_err = 0, n_wr = 0;

  function automatic vram_word lsw_of(input rgb30 d);
    return {d.g[9:2], d.b[9:2]};
  endfunction

  function automatic vram_word msw_of(input rgb30 d);
    return {8'hff, d.r[9:2]};
  endfunction

  function automatic void model_pixel(input rgb30 d, input bit e);
    half_coord a;
    a = half_coord'(m_base + half_coord'(2 * m_pix));
    exp_wr.push_back('{addr: a, data: lsw_of(d), hi: 1'b0});
    exp_wr.push_back('{addr: half_coord'(a + 16'd1), data: msw_of(d), hi: 1'b1});
    if (e || m_pix == MAX) begin
      exp_ev.push_back(e && m_pix == MAX);
      m_in_frame = 0;
    end else begin
      m_pix++;
    end
  endfunction

  function automatic void model_beat(input rgb30 d, input bit s, input bit e,
                                     input bit en, input half_coord b);
    if (s) begin
      if (m_in_frame) exp_ev.push_back(1'b0);
      m_in_frame = 0;
      if (en) begin
        m_in_frame = 1;
        m_base     = b;
        m_pix      = 0;
        model_pixel(d, e);
      end
    end else if (m_in_frame) begin
      model_pixel(d, e);
    end
  endfunction

  // ---------------- monitor ----------------
  bit        prev_hold = 0;
  bit        prev_hs = 0;
  half_coord prev_addr = '0;
  vram_word  prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_wr.delete();
      exp_ev.delete();
      m_in_frame = 0;
      prev_hold  = 0;
      prev_hs    = 0;
    end else begin
      if (frame_done || frame_err) begin
        check("pulse_follows_handshake", prev_hs, 1);
        check("pulse_exclusive", frame_done && frame_err, 0);
        check("pulse_expected", exp_ev.size() != 0, 1);
        if (exp_ev.size() != 0) check("pulse_kind_done", frame_done, exp_ev.pop_front());
        if (frame_done) n_done++;
        if (frame_err) n_err++;
      end
      if (fb_write) check("ready_low_while_writing", scan_ready, 0);
      if (prev_hold) begin
        check("write_held_on_wait", fb_write, 1);
        check("addr_stable_on_wait", fb_address, prev_addr);
        check("data_stable_on_wait", fb_writedata, prev_data);
      end
      prev_hs = 0;
      if (fb_write && !fb_waitrequest) begin
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          check("write_addr", fb_address, w.addr);
          check("write_data", fb_writedata, w.data);
          if (w.hi && w.addr != 16'hxxxx && exp_wr.size() == 0) prev_hs = 1;
          else if (w.hi) prev_hs = 1;
        end
        wlog.push_back('{addr: fb_address, data: fb_writedata, hi: 1'b0});
        n_wr++;
      end
      if (scan_valid && scan_ready) begin
        if (scan_startofpacket && m_in_frame) prev_hs = 1;
        model_beat(scan_data, scan_startofpacket, scan_endofpacket, enable, fb_base);
      end
      prev_hold = fb_write && fb_waitrequest;
      prev_addr = fb_address;
      prev_data = fb_writedata;
    end
  end

  // ---------------- waitrequest generator ----------------
  int wait_mode = 0;
  int stall_cnt = 0;

  always @(posedge clk) begin
    #1;
    case (wait_mode)
      0: fb_waitrequest = 1'b0;
      1: fb_waitrequest = ($urandom_range(0, 3) == 0);
      default: begin
        fb_waitrequest = (stall_cnt < 5);
        stall_cnt      = (stall_cnt + 1) % 6;
      end
    endcase
  end

  // ---------------- stimulus ----------------
  function automatic rgb30 rand_px();
    rgb30 p;
    p.r = 10'($urandom);
    p.g = 10'($urandom);
    p.b = 10'($urandom);
    return p;
  endfunction

  task automatic send_beat(input rgb30 d, input bit s, input bit e);
    bit done;
    done = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    scan_valid         = 1'b1;
    scan_data          = d;
    scan_startofpacket = s;
    scan_endofpacket   = e;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (scan_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check("beat_accept_timeout", 0, 1);
    scan_valid         = 1'b0;
    scan_startofpacket = 1'b0;
    scan_endofpacket   = 1'b0;
  endtask

  // Sends n beats, sop on the first; eop on the last when with_eop.
  task automatic send_frame(input int n, input bit with_eop);
    for (int i = 0; i < n; i++)
      send_beat(rand_px(), i == 0, with_eop && i == n - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int d0, e0, w0, lg;
  rgb30 px0;

  initial begin
    px0 = '{r: 10'h3ff, g: 10'h200, b: 10'h001};
    check("model_pin_lsw", lsw_of(px0), 16'h8000);
    check("model_pin_msw", msw_of(px0), 16'hffff);

    #12;
    check("reset_scan_ready", scan_ready, 1);
    check("reset_fb_write", fb_write, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_frame_err", frame_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Beats before any sop are dropped.
    w0 = n_wr;
    for (int i = 0; i < 5; i++) send_beat(rand_px(), 0, i == 4);
    idle(4);
    check("pre_sop_no_writes", n_wr - w0, 0);
    check("pre_sop_ready", scan_ready, 1);

    // Full frame with a known first pixel and no stalls.
    wlog.delete();
    d0 = n_done; e0 = n_err;
    enable  = 1'b1;
    fb_base = 16'h1000;
    send_beat(px0, 1, 0);
    for (int i = 1; i <= MAX; i++) send_beat(rand_px(), 0, i == MAX);
    idle(6);
    check("full_lo_addr", wlog[0].addr, 16'h1000);
    check("full_lo_data", wlog[0].data, 16'h8000);
    check("full_hi_addr", wlog[1].addr, 16'h1001);
    check("full_hi_data", wlog[1].data, 16'hffff);
    lg = wlog.size();
    check("full_write_count", lg, 2 * (MAX + 1));
    if (lg > 0) check("full_last_addr", wlog[lg-1].addr, 16'h1000 + 2 * MAX + 1);
    check("full_done_count", n_done - d0, 1);
    check("full_err_count", n_err - e0, 0);

    // Whole frame with enable low.
    w0 = n_wr;
    enable = 1'b0;
    send_frame(MAX + 1, 1);
    idle(4);
    check("disabled_no_writes", n_wr - w0, 0);
    check("disabled_ready", scan_ready, 1);
    enable = 1'b1;

    // Short frame (eop at pixel 3) under 5-cycle stalls, then a restart.
    wait_mode = 2;
    w0 = n_wr; e0 = n_err;
    fb_base = 16'h2000;
    send_frame(4, 1);
    idle(20);
    check("short_write_count", n_wr - w0, 8);
    check("short_err_count", n_err - e0, 1);
    wait_mode = 1;
    d0 = n_done;
    fb_base = 16'h3000;
    send_frame(MAX + 1, 1);
    idle(10);
    check("restart_done_count", n_done - d0, 1);

    // Resync: sop at pixel 10 re-bases the frame.
    wlog.delete();
    d0 = n_done; e0 = n_err;
    fb_base = 16'h4000;
    for (int i = 0; i < 10; i++) send_beat(rand_px(), i == 0, 0);
    fb_base = 16'h5000;
    send_frame(MAX + 1, 1);
    idle(10);
    check("resync_new_base", wlog[20].addr, 16'h5000);
    check("resync_err_count", n_err - e0, 1);
    check("resync_done_count", n_done - d0, 1);

    // Long frame: no eop, extra beats discarded.
    w0 = n_wr; e0 = n_err;
    fb_base = 16'hfff0;
    send_frame(MAX + 4, 0);
    idle(10);
    check("long_write_count", n_wr - w0, 2 * (MAX + 1));
    check("long_err_count", n_err - e0, 1);

    // Reset while the msw write is stalled.
    wait_mode = 2;
    fb_base = 16'h6000;
    send_beat(rand_px(), 1, 0);
    begin
      bit hit;
      hit = 0;
      for (int t = 0; t < 50 && !hit; t++) begin
        @(negedge clk);
        if (fb_write && fb_address == 16'h6001) hit = 1;
      end
      check("reached_wr_hi", hit, 1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_fb_write", fb_write, 0);
    check("async_reset_ready", scan_ready, 1);
    check("async_reset_done", frame_done, 0);
    check("async_reset_err", frame_err, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_mode = 1;
    d0 = n_done;
    fb_base = 16'h7000;
    send_frame(MAX + 1, 1);
    idle(10);
    check("post_reset_done_count", n_done - d0, 1);

    // Random frames: random lengths, eop, enable, stalls.
    for (int f = 0; f < 8; f++) begin
      enable  = ($urandom_range(0, 4) != 0);
      fb_base = half_coord'($urandom);
      send_frame($urandom_range(1, MAX + 6), $urandom_range(0, 1) == 1);
    end
    idle(20);
    check("queue_writes_drained", exp_wr.size(), 0);
    check("queue_events_drained", exp_ev.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
